svc_rv_imem_loader: RTL

Byte-stream program loader that writes the instruction memory of a BRAM-based RISC-V SoC at run time. It replaces a fixed hex preload. It accepts a length-prefixed little-endian byte stream over a valid/ready interface and packs it into 32-bit words. Each word goes to the IMEM write port. The loader holds the core in reset until the image is complete, then releases it. It can optionally re-arm when the core signals ebreak, so a new program can be loaded.

---
 rtl/svc_rv_imem_loader_pkg.sv | 7 +
 rtl/svc_rv_imem_loader_if.sv | 14 +
 rtl/svc_rv_byte_packer.sv | 48 ++++
 rtl/svc_rv_imem_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/svc_rv_imem_loader_pkg.sv
// Shared types and constants for the run-time IMEM program loader.
package svc_rv_imem_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LOAD, S_RUN, S_ERR} state_e;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/svc_rv_imem_loader_if.sv
// Byte-stream input and IMEM write port of the loader, bundled for the top-level port list.
interface svc_rv_imem_loader_if #(
    parameter int IMEM_AW = 5
);
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_ready;
    logic               imem_wen;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;

    modport slave  (input  s_valid, s_data, output s_ready, imem_wen, imem_waddr, imem_wdata);
    modport master (output s_valid, s_data, input  s_ready, imem_wen, imem_waddr, imem_wdata);
endinterface

// File: rtl/svc_rv_byte_packer.sv
// Little-endian 8-to-32 packer: the first byte lands in bits [7:0], the word pulses out
// one cycle after its last byte.
module svc_rv_byte_packer
    import svc_rv_imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    input  logic        i_clr,
    output logic        o_fill,
    output logic [31:0] o_word,
    output logic        o_word_vld
);
    localparam int LW = $clog2(BYTES_PER_WORD);

    logic [LW-1:0] r_lane;
    logic [23:0]   r_buf;
    logic [31:0]   r_word;
    logic          r_word_vld;

    // Lets the caller act on the word in the same cycle its last byte is accepted.
    assign o_fill     = (r_lane == LW'(BYTES_PER_WORD - 1));
    assign o_word     = r_word;
    assign o_word_vld = r_word_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane     <= '0;
            r_buf      <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clr) begin
                r_lane <= '0;
            end else if (i_vld) begin
                r_lane <= r_lane + 1'b1;
                if (o_fill) begin
                    r_word     <= {i_byte, r_buf};
                    r_word_vld <= 1'b1;
                end else begin
                    r_buf[r_lane*8 +: 8] <= i_byte;
                end
            end
        end
    end
endmodule

// File: rtl/svc_rv_imem_loader.sv
// Loads a length-prefixed byte image into IMEM, holding the core in reset until it is complete.
module svc_rv_imem_loader
    import svc_rv_imem_loader_pkg::*;
#(
    parameter int IMEM_AW         = 5,
    parameter bit REARM_ON_EBREAK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svc_rv_imem_loader_if.slave  bus,
    input  logic                 ebreak,
    output logic                 cpu_rst_n,
    output logic                 loading,
    output logic                 err
);
    localparam logic [HDR_W:0] DEPTH = (HDR_W + 1)'(1) << IMEM_AW;

    state_e             r_state, w_state_nxt;
    logic [7:0]         r_nlo;
    logic [HDR_W-1:0]   r_n;
    logic [HDR_W-1:0]   w_n;
    logic [IMEM_AW:0]   r_widx;
    logic [IMEM_AW-1:0] r_waddr;
    logic               r_cpu_rst_n, r_err;
    logic               w_ready, w_loading, w_acc, w_wr_now, w_last, w_too_big;
    logic               w_fill, w_word_vld;
    logic [31:0]        w_word;

    assign w_n       = {bus.s_data, r_nlo};
    assign w_too_big = {1'b0, w_n} > DEPTH;
    assign w_acc     = bus.s_valid & w_ready;
    assign w_wr_now  = w_acc && (r_state == S_LOAD) && w_fill;
    // Index is one bit wider than the address so an image of exactly 2**IMEM_AW words terminates.
    assign w_last    = ((HDR_W + 1)'(r_widx) + 1'b1) == {1'b0, r_n};

    svc_rv_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vld      (w_acc && (r_state == S_LOAD)),
        .i_byte     (bus.s_data),
        .i_clr      ((r_state == S_IDLE) || (r_state == S_ERR)),
        .o_fill     (w_fill),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_loading   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_acc) w_state_nxt = S_HDR1;
            end
            S_HDR1: begin
                w_ready   = 1'b1;
                w_loading = 1'b1;
                if (w_acc) begin
                    if (w_n == '0)     w_state_nxt = S_RUN;
                    else if (w_too_big) w_state_nxt = S_ERR;
                    else                w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready   = 1'b1;
                w_loading = 1'b1;
                if (w_wr_now && w_last) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (ebreak && REARM_ON_EBREAK) w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                w_ready = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_nlo       <= '0;
            r_n         <= '0;
            r_widx      <= '0;
            r_waddr     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc && (r_state == S_IDLE)) r_nlo <= bus.s_data;
            if (w_acc && (r_state == S_HDR1)) begin
                r_n    <= w_n;
                r_widx <= '0;
            end
            if (w_wr_now) begin
                r_waddr <= r_widx[IMEM_AW-1:0];
                r_widx  <= r_widx + 1'b1;
            end
            // Released one cycle after entering RUN so the final IMEM write lands first.
            r_cpu_rst_n <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
            r_err       <= r_err | (w_state_nxt == S_ERR);
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.imem_wen   = w_word_vld;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = w_word;
    assign cpu_rst_n      = r_cpu_rst_n;
    assign loading        = w_loading;
    assign err            = r_err;
endmodule
